wb_dram_tester: RTL and testbench

WB_DRAM_TESTER -- requirements
Module: wb_dram_tester

---
 rtl/wb_dram_tester_if.sv | 23 ++
 rtl/wb_dram_tester.sv | 165 ++++++++++++++++
 tb/tb_wb_dram_tester.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_dram_tester_if.sv
// Pipelined Wishbone link between the DRAM tester (master) and the memory port (slave).
interface wb_dram_tester_if;
   logic [27:0] wb_adr;
   logic [31:0] wb_dat_w;
   logic [31:0] wb_dat_r;
   logic [3:0]  wb_sel;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic        wb_stall;
   logic        wb_ack;
   logic        wb_err;

   modport master (
      output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
      input  wb_dat_r, wb_stall, wb_ack, wb_err
   );

   modport slave (
      input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
      output wb_dat_r, wb_stall, wb_ack, wb_err
   );
endinterface

// File: rtl/wb_dram_tester.sv
// Write-then-read-back DRAM tester: fills a word range with an address-derived
// pattern over pipelined Wishbone, reads it back and reports mismatches or bus faults.
module wb_dram_tester #(
   parameter logic [31:0] SEED    = 32'hA5A5_5A5A,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init_done,
   input  logic             start,
   input  logic [27:0]      base_adr,
   input  logic [27:0]      num_words,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             bus_fault,
   output logic [15:0]      err_count,
   output logic [27:0]      first_err_adr,
   wb_dram_tester_if.master wb
);

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_ACK,
      RD_REQ,
      RD_ACK,
      FIN
   } state_t;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   state_t        state;
   logic [27:0]   idx;
   logic [27:0]   base_q;
   logic [27:0]   num_q;
   logic [TW-1:0] timer;
   logic          cyc_q;
   logic          stb_q;
   logic          we_q;
   logic [27:0]   adr_q;
   logic [31:0]   dat_q;

   logic [27:0]   cur_adr;
   logic [27:0]   next_idx;

   function automatic logic [31:0] pattern(input logic [27:0] a);
      return {4'b0, a} ^ SEED;
   endfunction

   // Range addresses wrap naturally at 2^28 through the 28-bit adder.
   assign cur_adr  = base_q + idx;
   assign next_idx = idx + 28'd1;

   assign wb.wb_adr   = adr_q;
   assign wb.wb_dat_w = dat_q;
   assign wb.wb_sel   = 4'hF;
   assign wb.wb_cyc   = cyc_q;
   assign wb.wb_stb   = stb_q;
   assign wb.wb_we    = we_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         base_q        <= '0;
         num_q         <= '0;
         timer         <= '0;
         cyc_q         <= 1'b0;
         stb_q         <= 1'b0;
         we_q          <= 1'b0;
         adr_q         <= '0;
         dat_q         <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         bus_fault     <= 1'b0;
         err_count     <= '0;
         first_err_adr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && init_done) begin
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  pass          <= 1'b0;
                  bus_fault     <= 1'b0;
                  err_count     <= '0;
                  first_err_adr <= '0;
                  idx           <= '0;
                  base_q        <= base_adr;
                  num_q         <= num_words;
                  if (num_words == 28'd0) begin
                     state <= FIN;
                  end else begin
                     cyc_q <= 1'b1;
                     stb_q <= 1'b1;
                     we_q  <= 1'b1;
                     adr_q <= base_adr;
                     dat_q <= pattern(base_adr);
                     state <= WR_REQ;
                  end
               end
            end

            // With stb low this is the one-cycle cyc gap after an ack; relaunch next.
            WR_REQ, RD_REQ: begin
               if (!stb_q) begin
                  cyc_q <= 1'b1;
                  stb_q <= 1'b1;
                  we_q  <= (state == WR_REQ);
                  adr_q <= cur_adr;
                  dat_q <= (state == WR_REQ) ? pattern(cur_adr) : 32'd0;
               end else if (!wb.wb_stall) begin
                  stb_q <= 1'b0;
                  timer <= '0;
                  state <= (state == WR_REQ) ? WR_ACK : RD_ACK;
               end
            end

            WR_ACK, RD_ACK: begin
               if (wb.wb_err || (!wb.wb_ack && timer == TIMER_LAST)) begin
                  cyc_q     <= 1'b0;
                  we_q      <= 1'b0;
                  bus_fault <= 1'b1;
                  state     <= FIN;
               end else if (wb.wb_ack) begin
                  cyc_q <= 1'b0;
                  we_q  <= 1'b0;
                  idx   <= next_idx;
                  if (state == RD_ACK && wb.wb_dat_r != pattern(adr_q)) begin
                     if (err_count == 16'd0) begin
                        first_err_adr <= adr_q;
                     end
                     if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                     end
                  end
                  if (next_idx == num_q) begin
                     idx   <= '0;
                     state <= (state == WR_ACK) ? RD_REQ : FIN;
                  end else begin
                     state <= (state == WR_ACK) ? WR_REQ : RD_REQ;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               pass  <= (err_count == 16'd0) && !bus_fault;
               cyc_q <= 1'b0;
               stb_q <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_dram_tester.sv
// Randomised bench for wb_dram_tester: a Wishbone memory responder plus a
// transaction-level model of the expected bus traffic and final verdict.
module tb_wb_dram_tester;

   localparam logic [31:0] SEED    = 32'hA5A5_5A5A;
   localparam int          TIMEOUT = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        init_done;
   logic        start;
   logic [27:0] base_adr;
   logic [27:0] num_words;
   logic        busy;
   logic        done;
   logic        pass;
   logic        bus_fault;
   logic [15:0] err_count;
   logic [27:0] first_err_adr;

   wb_dram_tester_if bus ();

   wb_dram_tester #(.SEED(SEED), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .init_done     (init_done),
      .start         (start),
      .base_adr      (base_adr),
      .num_words     (num_words),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .bus_fault     (bus_fault),
      .err_count     (err_count),
      .first_err_adr (first_err_adr),
      .wb            (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [27:0] adr;
      logic [31:0] dat;
   } txn_t;

   int vectors     = 0;
   int miscompares = 0;

   // Responder configuration
   int          stall_pct    = 0;
   int          max_delay    = 0;
   bit          never_ack    = 1'b0;
   int          err_on_write = 0;
   bit          flip_en      = 1'b0;
   logic [27:0] flip_adr     = '0;

   txn_t        exp_q[$];
   logic [27:0] adr_log[$];
   logic [31:0] dat_log[$];
   logic [31:0] mem [logic [27:0]];
   int          writes_seen = 0;

   function automatic logic [31:0] pattern(input logic [27:0] a);
      return {4'b0, a} ^ SEED;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory responder and per-cycle bus compare against the expected transaction list.
   initial begin : responder
      bit          pending;
      int          delay_cnt;
      logic [27:0] p_adr;
      logic [31:0] p_dat;
      bit          p_we;
      int          p_wnum;
      bit          held;
      logic [61:0] held_val;
      bit          prev_ack;
      txn_t        e;
      pending  = 1'b0;
      held     = 1'b0;
      prev_ack = 1'b0;
      delay_cnt = 0;
      p_wnum   = 0;
      bus.wb_stall = 1'b0;
      bus.wb_ack   = 1'b0;
      bus.wb_err   = 1'b0;
      bus.wb_dat_r = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pending  = 1'b0;
            held     = 1'b0;
            prev_ack = 1'b0;
            bus.wb_ack   = 1'b0;
            bus.wb_err   = 1'b0;
            bus.wb_stall = 1'b0;
            continue;
         end
         checkOutput("sel_const", bus.wb_sel, 4'hF);
         if (held)
            checkOutput("stall_hold", {bus.wb_stb, bus.wb_we, bus.wb_adr, bus.wb_dat_w}, held_val);
         if (prev_ack)
            checkOutput("cyc_gap", bus.wb_cyc, 1'b0);
         if (bus.wb_cyc)
            checkOutput("busy_in_cycle", busy, 1'b1);
         if (!bus.wb_cyc) pending = 1'b0;

         bus.wb_ack   = 1'b0;
         bus.wb_err   = 1'b0;
         bus.wb_dat_r = $urandom;
         prev_ack     = 1'b0;
         if (pending && !never_ack) begin
            if (delay_cnt == 0) begin
               bus.wb_ack = 1'b1;
               if (p_we) begin
                  if (err_on_write != 0 && p_wnum == err_on_write) bus.wb_err = 1'b1;
                  else mem[p_adr] = p_dat;
               end else begin
                  bus.wb_dat_r = mem.exists(p_adr) ? mem[p_adr] : 32'hDEAD_BEEF;
                  if (flip_en && p_adr == flip_adr) bus.wb_dat_r = bus.wb_dat_r ^ 32'd1;
               end
               pending  = 1'b0;
               prev_ack = 1'b1;
            end else begin
               delay_cnt--;
            end
         end

         bus.wb_stall = ($urandom_range(99) < stall_pct);
         held     = bus.wb_stb && bus.wb_stall;
         held_val = {1'b1, bus.wb_we, bus.wb_adr, bus.wb_dat_w};
         if (bus.wb_cyc && bus.wb_stb && !bus.wb_stall) begin
            checkOutput("one_outstanding", pending, 1'b0);
            checkOutput("txn_avail", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               checkOutput("txn_we_adr", {bus.wb_we, bus.wb_adr}, {e.we, e.adr});
               if (e.we) checkOutput("txn_dat_w", bus.wb_dat_w, e.dat);
            end
            pending   = 1'b1;
            delay_cnt = $urandom_range(max_delay);
            p_adr     = bus.wb_adr;
            p_dat     = bus.wb_dat_w;
            p_we      = bus.wb_we;
            adr_log.push_back(bus.wb_adr);
            dat_log.push_back(bus.wb_dat_w);
            if (bus.wb_we) begin
               writes_seen++;
               p_wnum = writes_seen;
            end
         end
      end
   end

   task automatic buildModel(input logic [27:0] base, input logic [27:0] num);
      txn_t t;
      exp_q.delete();
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < int'(num); i++) begin
            t.we  = (ph == 0);
            t.adr = 28'(base + 28'(i));
            t.dat = (ph == 0) ? pattern(t.adr) : 32'd0;
            exp_q.push_back(t);
         end
      end
   endtask

   task automatic applyStimulus(input logic [27:0] base, input logic [27:0] num, input bit restart);
      @(negedge clk);
      buildModel(base, num);
      adr_log.delete();
      dat_log.delete();
      writes_seen = 0;
      base_adr  = base;
      num_words = num;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("first_stb_latency", bus.wb_stb, num != 28'd0);
      checkOutput("busy_after_start", busy, 1'b1);
      checkOutput("done_cleared", done, 1'b0);
      if (restart) begin
         repeat (3) @(negedge clk);
         base_adr  = base + 28'h40;
         num_words = num + 28'd3;
         start     = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic waitDone(input int limit, output int cycles);
      cycles = 0;
      while (!done && cycles < limit) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("done_within_bound", done, 1'b1);
   endtask

   // Verdict expected from the flip configuration over the tested range.
   task automatic checkVerdict(input logic [27:0] base, input logic [27:0] num, input bit fault);
      int          errs;
      logic [27:0] first;
      logic [27:0] a;
      errs  = 0;
      first = '0;
      if (!fault) begin
         for (int i = 0; i < int'(num); i++) begin
            a = 28'(base + 28'(i));
            if (flip_en && a == flip_adr) begin
               if (errs == 0) first = a;
               errs++;
            end
         end
      end
      checkOutput("pass", pass, !fault && errs == 0);
      checkOutput("bus_fault", bus_fault, fault);
      checkOutput("err_count", err_count, 16'(errs));
      checkOutput("first_err_adr", first_err_adr, first);
      checkOutput("idle_after_done", {busy, bus.wb_cyc, bus.wb_stb}, 3'b000);
      if (!fault) checkOutput("all_txns_seen", exp_q.size(), 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int          cycles;
      bit          found;
      logic [27:0] b;
      logic [27:0] n;
      rst_n     = 1'b0;
      init_done = 1'b1;
      start     = 1'b0;
      base_adr  = '0;
      num_words = '0;

      #3;
      checkOutput("reset_bus", {bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.wb_adr, bus.wb_dat_w}, 63'd0);
      checkOutput("reset_status", {busy, done, pass, bus_fault, err_count, first_err_adr}, 48'd0);
      checkOutput("reset_sel", bus.wb_sel, 4'hF);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] ideal memory, base 0x100, 16 words");
      applyStimulus(28'h100, 28'd16, 1'b0);
      waitDone(2000, cycles);
      checkVerdict(28'h100, 28'd16, 1'b0);
      checkOutput("lit_txn_count", adr_log.size(), 32);
      checkOutput("lit_first_dat", dat_log[0], 32'hA5A5_5B5A);
      checkOutput("lit_read_start", adr_log[16], 28'h100);
      checkOutput("lit_run_cycles", cycles, 96);

      $display("[TB] bit flip at 0x105");
      flip_en  = 1'b1;
      flip_adr = 28'h105;
      applyStimulus(28'h100, 28'd16, 1'b0);
      waitDone(2000, cycles);
      checkVerdict(28'h100, 28'd16, 1'b0);
      checkOutput("lit_flip_first", {pass, err_count, first_err_adr}, {1'b0, 16'd1, 28'h105});
      flip_en = 1'b0;

      $display("[TB] address wrap");
      applyStimulus(28'hFFF_FFFE, 28'd4, 1'b0);
      waitDone(2000, cycles);
      checkVerdict(28'hFFF_FFFE, 28'd4, 1'b0);
      checkOutput("lit_wrap_a0", adr_log[0], 28'hFFF_FFFE);
      checkOutput("lit_wrap_a1", adr_log[1], 28'hFFF_FFFF);
      checkOutput("lit_wrap_a2", adr_log[2], 28'h000_0000);
      checkOutput("lit_wrap_a3", adr_log[3], 28'h000_0001);
      checkOutput("lit_wrap_r0", adr_log[4], 28'hFFF_FFFE);
      checkOutput("lit_wrap_dat", dat_log[0], 32'hAA5A_A5A4);

      $display("[TB] random stall and ack delay");
      stall_pct = 50;
      max_delay = 5;
      for (int r = 0; r < 4; r++) begin
         b = 28'($urandom);
         n = 28'($urandom_range(24, 8));
         flip_en  = (r % 2 == 1);
         flip_adr = 28'(b + 28'($urandom_range(int'(n) - 1)));
         applyStimulus(b, n, r == 0);
         waitDone(5000, cycles);
         checkVerdict(b, n, 1'b0);
      end
      flip_en = 1'b0;

      $display("[TB] responder never acks");
      stall_pct = 0;
      max_delay = 0;
      never_ack = 1'b1;
      applyStimulus(28'h200, 28'd8, 1'b0);
      waitDone(TIMEOUT + 50, cycles);
      checkVerdict(28'h200, 28'd8, 1'b1);
      checkOutput("timeout_window", cycles >= TIMEOUT && cycles <= TIMEOUT + 4, 1'b1);
      never_ack = 1'b0;

      $display("[TB] err together with ack on third write");
      max_delay    = 2;
      err_on_write = 3;
      applyStimulus(28'h200, 28'd8, 1'b0);
      waitDone(2000, cycles);
      checkVerdict(28'h200, 28'd8, 1'b1);
      checkOutput("err_stops_run", adr_log.size(), 3);
      err_on_write = 0;

      $display("[TB] start ignored without init_done");
      init_done = 1'b0;
      @(negedge clk);
      num_words = 28'd4;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("start_ignored_no_init", {busy, bus.wb_cyc, done}, 3'b001);
      init_done = 1'b1;

      $display("[TB] reset during read ack");
      max_delay = 5;
      applyStimulus(28'h300, 28'd4, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 500 && !found; k++) begin
         @(negedge clk);
         if (bus.wb_cyc && !bus.wb_stb && !bus.wb_we) found = 1'b1;
      end
      checkOutput("reached_rd_ack", found, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrun_reset_bus", {bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.wb_adr, bus.wb_dat_w}, 63'd0);
      checkOutput("midrun_reset_status", {busy, done, pass, bus_fault, err_count, first_err_adr}, 48'd0);
      checkOutput("midrun_reset_sel", bus.wb_sel, 4'hF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();

      applyStimulus(28'h300, 28'd0, 1'b0);
      waitDone(20, cycles);
      checkVerdict(28'h300, 28'd0, 1'b0);
      checkOutput("zero_len_no_bus", adr_log.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
